// File: rtl/oc8051_uart_peer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : oc8051_uart_peer
// Brief    : Far-end serial peer for 8051 modes 1/2/3 framing (8 or 9 data bits)
// Revision : 1.0
// ============================================================================
module oc8051_uart_peer #(
    parameter int CLK_DIV = 16,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       nine_bit,
    input  logic [7:0] tx_data,
    input  logic       tx_bit8,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_bit8,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam logic [CNT_W-1:0] c_bit_last = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] c_smp_a    = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] c_smp_b    = CNT_W'(CLK_DIV / 2);
    localparam logic [CNT_W-1:0] c_smp_c    = CNT_W'(CLK_DIV / 2 + 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_start = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_bit8  = 3'd3;
    localparam logic [2:0] c_st_stop  = 3'd4;

    // ---------------- transmitter ----------------
    logic [2:0]       tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_b8_q, tx_b8_d;
    logic             tx_nine_q, tx_nine_d;
    logic             txd_q, txd_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_b8_d    = tx_b8_q;
        tx_nine_d  = tx_nine_q;
        txd_d      = txd_q;
        if (tx_state_q == c_st_idle) begin
            if (tx_valid) begin
                tx_state_d = c_st_start;
                tx_cnt_d   = '0;
                tx_shift_d = tx_data;
                tx_b8_d    = tx_bit8;
                tx_nine_d  = nine_bit;
                txd_d      = 1'b0;
            end
        end else if (tx_cnt_q != c_bit_last) begin
            tx_cnt_d = tx_cnt_q + 1'b1;
        end else begin
            // Next bit level is registered on the boundary so txd stays glitch-free.
            tx_cnt_d = '0;
            case (tx_state_q)
                c_st_start: begin
                    tx_state_d = c_st_data;
                    tx_bit_d   = '0;
                    txd_d      = tx_shift_q[0];
                end
                c_st_data: begin
                    if (tx_bit_q != 3'd7) begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end else if (tx_nine_q) begin
                        tx_state_d = c_st_bit8;
                        txd_d      = tx_b8_q;
                    end else begin
                        tx_state_d = c_st_stop;
                        txd_d      = 1'b1;
                    end
                end
                c_st_bit8: begin
                    tx_state_d = c_st_stop;
                    txd_d      = 1'b1;
                end
                default: begin
                    tx_state_d = c_st_idle;
                    txd_d      = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= c_st_idle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_b8_q    <= 1'b0;
            tx_nine_q  <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_b8_q    <= tx_b8_d;
            tx_nine_q  <= tx_nine_d;
            txd_q      <= txd_d;
        end
    end

    assign tx_ready = (tx_state_q == c_st_idle);
    assign txd      = txd_q;

    // ---------------- receiver ----------------
    logic             rx_sync1_q, rx_sync1_d, rx_sync2_q, rx_sync2_d, rx_prev_q, rx_prev_d;
    logic [2:0]       rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_b8_q, rx_b8_d;
    logic             rx_nine_q, rx_nine_d;
    logic [1:0]       rx_vote_q, rx_vote_d;
    logic             rx_done_q, rx_done_d;
    logic             rx_stop_q, rx_stop_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_bit8_q, rx_bit8_d;
    logic             rx_err_q, rx_err_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_ovr_q, rx_ovr_d;
    logic             w_rxd_s, w_maj;

    assign w_rxd_s = rx_sync2_q;
    assign w_maj   = (rx_vote_q[0] & rx_vote_q[1]) | (rx_vote_q[0] & w_rxd_s) |
                     (rx_vote_q[1] & w_rxd_s);

    always_comb begin
        rx_sync1_d = rxd;
        rx_sync2_d = rx_sync1_q;
        rx_prev_d  = rx_sync2_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_b8_d    = rx_b8_q;
        rx_nine_d  = rx_nine_q;
        rx_vote_d  = rx_vote_q;
        rx_done_d  = 1'b0;
        rx_stop_d  = rx_stop_q;
        rx_data_d  = rx_data_q;
        rx_bit8_d  = rx_bit8_q;
        rx_err_d   = rx_err_q;
        rx_valid_d = rx_valid_q;
        rx_ovr_d   = 1'b0;
        if (rx_state_q == c_st_idle) begin
            if (rx_prev_q && !w_rxd_s) begin
                rx_state_d = c_st_start;
                rx_cnt_d   = '0;
                rx_nine_d  = nine_bit;
                rx_b8_d    = 1'b0;
            end
        end else begin
            rx_cnt_d = (rx_cnt_q == c_bit_last) ? '0 : rx_cnt_q + 1'b1;
            if (rx_cnt_q == c_smp_a) rx_vote_d[0] = w_rxd_s;
            if (rx_cnt_q == c_smp_b) rx_vote_d[1] = w_rxd_s;
            // Third vote is the live sample; the decision is taken on that count.
            if (rx_cnt_q == c_smp_c) begin
                case (rx_state_q)
                    c_st_start: begin
                        rx_state_d = w_maj ? c_st_idle : c_st_data;
                        rx_bit_d   = '0;
                    end
                    c_st_data: begin
                        rx_shift_d = {w_maj, rx_shift_q[7:1]};
                        rx_bit_d   = rx_bit_q + 1'b1;
                        if (rx_bit_q == 3'd7) rx_state_d = rx_nine_q ? c_st_bit8 : c_st_stop;
                    end
                    c_st_bit8: begin
                        rx_b8_d    = w_maj;
                        rx_state_d = c_st_stop;
                    end
                    default: begin
                        rx_state_d = c_st_idle;
                        rx_done_d  = 1'b1;
                        rx_stop_d  = w_maj;
                    end
                endcase
            end
        end
        if (rx_done_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = rx_shift_q;
                rx_bit8_d  = rx_b8_q;
                rx_err_d   = ~rx_stop_q;
                rx_valid_d = 1'b1;
            end else begin
                rx_ovr_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= c_st_idle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_b8_q    <= 1'b0;
            rx_nine_q  <= 1'b0;
            rx_vote_q  <= 2'b11;
            rx_done_q  <= 1'b0;
            rx_stop_q  <= 1'b1;
            rx_data_q  <= '0;
            rx_bit8_q  <= 1'b0;
            rx_err_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            rx_sync1_q <= rx_sync1_d;
            rx_sync2_q <= rx_sync2_d;
            rx_prev_q  <= rx_prev_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_b8_q    <= rx_b8_d;
            rx_nine_q  <= rx_nine_d;
            rx_vote_q  <= rx_vote_d;
            rx_done_q  <= rx_done_d;
            rx_stop_q  <= rx_stop_d;
            rx_data_q  <= rx_data_d;
            rx_bit8_q  <= rx_bit8_d;
            rx_err_q   <= rx_err_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_bit8      = rx_bit8_q;
    assign rx_frame_err = rx_err_q;
    assign rx_valid     = rx_valid_q;
    assign rx_overrun   = rx_ovr_q;

endmodule
`default_nettype wire
